// File: rtl/salsa20_pkg.sv
// salsa20_pkg: shared types, constants and quarterround index tables for the Salsa20/ChaCha permutation core.
//   FSM encodings (IDLE, ROUND, FINAL, DONE), word geometry (32-bit words, 16 per block),
//   rotation amounts 16/12/8/7, column/diagonal quarterround index tables and a rotate helper.
package salsa20_pkg;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 16;
    localparam int ROT_A     = 16;
    localparam int ROT_B     = 12;
    localparam int ROT_C     = 8;
    localparam int ROT_D     = 7;

    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    // Entry [4*g + p] is the state word feeding operand p (a,b,c,d) of quarterround group g.
    localparam logic [3:0] COL_IDX [16] = '{
        4'd0, 4'd4, 4'd8,  4'd12,
        4'd1, 4'd5, 4'd9,  4'd13,
        4'd2, 4'd6, 4'd10, 4'd14,
        4'd3, 4'd7, 4'd11, 4'd15
    };
    localparam logic [3:0] DIAG_IDX [16] = '{
        4'd0, 4'd5, 4'd10, 4'd15,
        4'd1, 4'd6, 4'd11, 4'd12,
        4'd2, 4'd7, 4'd8,  4'd13,
        4'd3, 4'd4, 4'd9,  4'd14
    };

    function automatic word_t rotl(input word_t x, input int n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction
endpackage

// File: rtl/salsa20_qr.sv
// salsa20_qr: combinational ChaCha-style quarterround, all arithmetic mod 2^32.
//   i_a..i_d : input words a,b,c,d
//   o_a..o_d : quarterround results
module salsa20_qr
    import salsa20_pkg::*;
(
    input  word_t i_a,
    input  word_t i_b,
    input  word_t i_c,
    input  word_t i_d,
    output word_t o_a,
    output word_t o_b,
    output word_t o_c,
    output word_t o_d
);
    word_t w_a0, w_b0, w_c0, w_d0, w_a1, w_b1, w_c1, w_d1;

    assign w_a0 = i_a + i_b;
    assign w_d0 = rotl(i_d ^ w_a0, ROT_A);
    assign w_c0 = i_c + w_d0;
    assign w_b0 = rotl(i_b ^ w_c0, ROT_B);
    assign w_a1 = w_a0 + w_b0;
    assign w_d1 = rotl(w_d0 ^ w_a1, ROT_C);
    assign w_c1 = w_c0 + w_d1;
    assign w_b1 = rotl(w_b0 ^ w_c1, ROT_D);

    assign o_a = w_a1;
    assign o_b = w_b1;
    assign o_c = w_c1;
    assign o_d = w_d1;
endmodule

// File: rtl/salsa20_round_core.sv
// salsa20_round_core: iterative 16-word block permutation, ROUNDS alternating column/diagonal rounds
//   using NUM_QR parallel quarterrounds per cycle, result returned over a valid/ready handshake.
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   in_valid   : state_in valid          in_ready  : idle, will accept state_in
//   state_in   : word i at [32i+31:32i]  state_out : result, same packing
//   out_valid  : state_out valid, held until taken
//   out_ready  : consumer accepts state_out
//   Build option: define SALSA20_FEEDFORWARD_EN to add the original input to the permuted state.
module salsa20_round_core
    import salsa20_pkg::*;
#(
    parameter int NUM_QR = 4,
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] state_out
);
    localparam int SUBS = 4 / NUM_QR;

    state_t r_fsm, w_fsm_nxt;
    logic [1:0] r_qr_ctr;
    logic [4:0] r_round_ctr;
    logic       w_wrap, w_last, w_accept;
    logic [NUM_WORDS-1:0][WORD_W-1:0] r_state, w_next, w_result;
    logic [NUM_QR-1:0][3:0][3:0]      w_idx;
    logic [NUM_QR-1:0][3:0][WORD_W-1:0] w_qin, w_qout;

    assign w_wrap   = r_qr_ctr == 2'(SUBS - 1);
    assign w_last   = w_wrap && (r_round_ctr == 5'(ROUNDS - 1));
    assign w_accept = in_valid && in_ready;

    // Sub-step k of a round covers groups k*NUM_QR .. k*NUM_QR+NUM_QR-1; round parity picks the table.
    always_comb begin
        w_idx = '0;
        w_qin = '0;
        for (int j = 0; j < NUM_QR; j++) begin
            for (int p = 0; p < 4; p++) begin
                w_idx[j][p] = r_round_ctr[0] ? DIAG_IDX[4'((int'(r_qr_ctr) * NUM_QR + j) * 4 + p)]
                                             : COL_IDX[4'((int'(r_qr_ctr) * NUM_QR + j) * 4 + p)];
                w_qin[j][p] = r_state[w_idx[j][p]];
            end
        end
    end

    for (genvar j = 0; j < NUM_QR; j++) begin : g_qr
        salsa20_qr u_qr (
            .i_a(w_qin[j][0]),
            .i_b(w_qin[j][1]),
            .i_c(w_qin[j][2]),
            .i_d(w_qin[j][3]),
            .o_a(w_qout[j][0]),
            .o_b(w_qout[j][1]),
            .o_c(w_qout[j][2]),
            .o_d(w_qout[j][3])
        );
    end

    // Groups in one sub-step touch disjoint words, so write-backs never collide.
    always_comb begin
        w_next = r_state;
        for (int j = 0; j < NUM_QR; j++) begin
            for (int p = 0; p < 4; p++) begin
                w_next[w_idx[j][p]] = w_qout[j][p];
            end
        end
    end

`ifdef SALSA20_FEEDFORWARD_EN
    logic [NUM_WORDS-1:0][WORD_W-1:0] r_input;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_input <= '0;
        end else if (w_accept) begin
            r_input <= state_in;
        end
    end

    always_comb begin
        w_result = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            w_result[i] = r_state[i] + r_input[i];
        end
    end
`else
    assign w_result = r_state;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_fsm_nxt = ROUND;
            end
            ROUND:   w_fsm_nxt = w_last ? FINAL : ROUND;
            FINAL:   w_fsm_nxt = DONE;
            DONE:    w_fsm_nxt = (out_valid && out_ready) ? IDLE : DONE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= '0;
            r_qr_ctr    <= '0;
            r_round_ctr <= '0;
            out_valid   <= 1'b0;
            state_out   <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= state_in;
                        r_qr_ctr    <= '0;
                        r_round_ctr <= '0;
                    end
                end
                ROUND: begin
                    r_state     <= w_next;
                    r_qr_ctr    <= w_wrap ? 2'd0 : r_qr_ctr + 2'd1;
                    r_round_ctr <= w_wrap ? r_round_ctr + 5'd1 : r_round_ctr;
                end
                FINAL: begin
                    state_out <= w_result;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_salsa20_round_core.sv
// tb_salsa20_round_core: self-checking bench for salsa20_round_core with a software block-function model.
module tb_salsa20_round_core;
`ifdef SALSA20_FEEDFORWARD_EN
    localparam bit FF = 1'b1;
`else
    localparam bit FF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [511:0] state_in;
    logic [3:0]   iv, ordy, irdy, ov;
    logic [511:0] so [4];
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    salsa20_round_core #(.NUM_QR(4), .ROUNDS(20)) u0 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(irdy[0]), .state_in(state_in),
        .out_valid(ov[0]), .out_ready(ordy[0]), .state_out(so[0]));
    salsa20_round_core #(.NUM_QR(2), .ROUNDS(20)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(irdy[1]), .state_in(state_in),
        .out_valid(ov[1]), .out_ready(ordy[1]), .state_out(so[1]));
    salsa20_round_core #(.NUM_QR(1), .ROUNDS(20)) u2 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(irdy[2]), .state_in(state_in),
        .out_valid(ov[2]), .out_ready(ordy[2]), .state_out(so[2]));
    salsa20_round_core #(.NUM_QR(4), .ROUNDS(2)) u3 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[3]), .in_ready(irdy[3]), .state_in(state_in),
        .out_valid(ov[3]), .out_ready(ordy[3]), .state_out(so[3]));

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [15:0][31:0] qrm(input logic [15:0][31:0] x, input int a, input int b,
                                               input int c, input int d);
        x[a] += x[b]; x[d] = rl(x[d] ^ x[a], 16);
        x[c] += x[d]; x[b] = rl(x[b] ^ x[c], 12);
        x[a] += x[b]; x[d] = rl(x[d] ^ x[a], 8);
        x[c] += x[d]; x[b] = rl(x[b] ^ x[c], 7);
        return x;
    endfunction

    function automatic logic [511:0] model(input logic [511:0] din, input int rounds);
        logic [15:0][31:0] x, s;
        x = din;
        s = din;
        for (int r = 0; r < rounds; r += 2) begin
            x = qrm(x, 0, 4, 8, 12);  x = qrm(x, 1, 5, 9, 13);
            x = qrm(x, 2, 6, 10, 14); x = qrm(x, 3, 7, 11, 15);
            x = qrm(x, 0, 5, 10, 15); x = qrm(x, 1, 6, 11, 12);
            x = qrm(x, 2, 7, 8, 13);  x = qrm(x, 3, 4, 9, 14);
        end
        if (FF) for (int i = 0; i < 16; i++) x[i] += s[i];
        return x;
    endfunction

    function automatic logic [511:0] rnd_block();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one block to instance k, count edges from acceptance to out_valid, then take the result.
    task automatic run_block(input int k, input logic [511:0] din, output logic [511:0] dout,
                             output int lat);
        int t = 0;
        @(negedge clk);
        while (!irdy[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        state_in = din;
        iv[k] = 1'b1;
        @(negedge clk);
        iv[k] = 1'b0;
        lat = 0;
        while (!ov[k] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        dout = so[k];
        ordy[k] = 1'b1;
        @(negedge clk);
        ordy[k] = 1'b0;
    endtask

    typedef struct {
        logic [511:0] din;
        logic [511:0] exp;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tv [6];
        logic [511:0] got [6];
        logic [31:0] rw [16] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                                 32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                 32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                                 32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        logic [511:0] d, o0, o1, o2, snap, pr;
        int l0, l1, l2, t;

        reset_n = 1'b0; iv = '0; ordy = '0; state_in = '0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", 512'(ov[0]), 512'(0));
        chk("reset state_out", so[0], '0);
        chk("reset in_ready", 512'(irdy[0]), 512'(1));
        reset_n = 1'b1;

        tv[0].din = '0;
        tv[0].exp = '0;
        for (int i = 0; i < 16; i++) tv[1].din[32*i +: 32] = rw[i];
        tv[1].exp = model(tv[1].din, 20);
        for (int i = 2; i < 6; i++) begin
            tv[i].din = rnd_block();
            tv[i].exp = model(tv[i].din, 20);
        end
        for (int i = 0; i < 6; i++) begin
            run_block(0, tv[i].din, got[i], l0);
            chk($sformatf("vec%0d state_out", i), got[i], tv[i].exp);
            chk($sformatf("vec%0d latency", i), 512'(l0), 512'(21));
        end
        chk("block word0", 512'(got[1][31:0]), 512'(FF ? 32'he4e7f110 : 32'h837778ab));
`ifdef SALSA20_FEEDFORWARD_EN
        chk("block word15", 512'(got[1][511:480]), 512'(32'h4e3c50a2));
`endif

        for (int n = 0; n < 2; n++) begin
            d = rnd_block();
            fork
                run_block(0, d, o0, l0);
                run_block(1, d, o1, l1);
                run_block(2, d, o2, l2);
            join
            chk("qr4 out", o0, model(d, 20));
            chk("qr2 out", o1, model(d, 20));
            chk("qr1 out", o2, model(d, 20));
            chk("qr4 lat", 512'(l0), 512'(21));
            chk("qr2 lat", 512'(l1), 512'(41));
            chk("qr1 lat", 512'(l2), 512'(81));
        end

        d = rnd_block();
        @(negedge clk);
        state_in = d; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0; t = 0;
        while (!ov[0] && t < 200) begin
            @(negedge clk);
            t++;
        end
        snap = so[0];
        chk("bp out", snap, model(d, 20));
        state_in = ~d; iv[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp state_out stable", so[0], snap);
            chk("bp in_ready low", 512'(irdy[0]), 512'(0));
            chk("bp out_valid held", 512'(ov[0]), 512'(1));
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;
        chk("bp out_valid cleared", 512'(ov[0]), 512'(0));
        chk("bp in_ready back", 512'(irdy[0]), 512'(1));
        chk("bp state_out kept", so[0], snap);

        d = rnd_block();
        @(negedge clk);
        state_in = d; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid reset out_valid", 512'(ov[0]), 512'(0));
        chk("mid reset state_out", so[0], '0);
        pr = u0.r_state;
        chk("mid reset state", pr, '0);
        @(negedge clk);
        reset_n = 1'b1;
        d = rnd_block();
        run_block(0, d, o0, l0);
        chk("post reset out", o0, model(d, 20));
        chk("post reset lat", 512'(l0), 512'(21));

        d = '0;
        d[0 +: 32]   = 32'h11111111;
        d[128 +: 32] = 32'h01020304;
        d[256 +: 32] = 32'h9b8d6f43;
        d[384 +: 32] = 32'h01234567;
        @(negedge clk);
        state_in = d; iv[3] = 1'b1;
        @(negedge clk);
        iv[3] = 1'b0;
        @(negedge clk);
        pr = u3.r_state;
        chk("r2 col word0", 512'(pr[0 +: 32]), 512'(32'hea2a92f4));
        chk("r2 col word4", 512'(pr[128 +: 32]), 512'(32'hcb1cf8ce));
        chk("r2 col word8", 512'(pr[256 +: 32]), 512'(32'h4581472e));
        chk("r2 col word12", 512'(pr[384 +: 32]), 512'(32'h5881c4bb));
        chk("r2 col word1", 512'(pr[32 +: 32]), 512'(0));
        t = 1;
        while (!ov[3] && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("r2 lat", 512'(t), 512'(3));
        chk("r2 out", so[3], model(d, 2));
        ordy[3] = 1'b1;
        @(negedge clk);
        ordy[3] = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/salsa20_round_core.md
# salsa20_round_core

- Iterative, parametrised Salsa20/ChaCha-family block permutation engine.
- Accepts a 16-word state and applies ROUNDS alternating column/diagonal rounds using NUM_QR parallel quarterround instances.
- Optionally adds the original input (feed-forward), then returns the 512-bit result over a valid/ready handshake.
- Sits between the key/nonce/counter state builder and the keystream XOR stage.

## Interface
- NUM_QR, 4: parallel quarterrounds per cycle; legal values 1, 2, 4.
- ROUNDS, 20: total rounds; even, 2..20 (8/12/20 in product, 2 for test).
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  state_in valid.
- in_ready  output  1  core idle, will accept state_in.
- state_in  input  512  word i at bits [32i+31:32i].
- out_valid  output  1  state_out valid, held until taken.
- out_ready  input  1  consumer accepts state_out.
- state_out  output  512  result, same word packing.

## Operation
- Quarterround QR(a,b,c,d), mod 2^32, in order:
  - a+=b; d^=a; d<<<=16
  - c+=d; b^=c; b<<<=12
  - a+=b; d^=a; d<<<=8
  - c+=d; b^=c; b<<<=7
- Even round index (0,2,..) is a column round: QR groups (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15).
- Odd round index is a diagonal round: QR groups (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
- Each round takes 4/NUM_QR cycles. Sub-step k applies groups k*NUM_QR .. k*NUM_QR+NUM_QR-1. Groups are disjoint, so results are independent of NUM_QR.
- FSM states: IDLE, ROUND, FINAL, DONE.
  - IDLE: in_ready=1. On in_valid && in_ready, load the working state (and the input copy if feed-forward is enabled), clear both counters, go to ROUND.
  - ROUND: apply one sub-step per cycle; qr_ctr counts 0..4/NUM_QR-1, and round_ctr increments when qr_ctr wraps. After the last sub-step of round ROUNDS-1, go to FINAL.
  - FINAL: register state_out (with or without feed-forward), set out_valid, go to DONE.
  - DONE: hold state_out and out_valid stable. On out_valid && out_ready, clear out_valid and go to IDLE.
- in_ready=0 in ROUND, FINAL and DONE; in_valid is ignored there. There is no overlap of blocks.
- Reset values: FSM=IDLE, counters=0, working state=0, out_valid=0, state_out=0.
  - in_ready reads 1 during reset, but the handshake is ignored while reset_n=0.
  - Asserting reset mid-operation discards the block; no partial output appears.
- state_out is only valid while out_valid=1; it keeps its last value after the handshake.

## Timing
- N = ROUNDS*4/NUM_QR compute cycles.
- Accept at edge E0, compute at edges E1..EN, out_valid=1 after edge E(N+1).
- Defaults give N=20, so out_valid rises 21 cycles after acceptance.
- out_ready high in the first DONE cycle → out_valid low and in_ready high one edge later.
- Minimum block period is N+3 cycles.
- Critical path: one quarterround (4 adds, 4 xors) plus the state mux.

## Configuration
- SALSA20_FEEDFORWARD_EN defined:
  - Keep a 512-bit copy of state_in.
  - state_out word i = permuted word i + input word i (mod 2^32), i.e. the final block function.
- Not defined:
  - No input copy register.
  - state_out = raw permuted state, for use in keystream/hash constructions that add externally.

## Structure
- Shared package salsa20_pkg holds:
  - FSM state encodings;
  - column and diagonal QR index tables;
  - rotation constants 16/12/8/7;
  - word width 32, word count 16.
- Sub-module: NUM_QR instances of the existing combinational salsa20_qr.
  - Operand selection is by index tables from round parity and qr_ctr.
  - Write-back goes to the selected words.

## Test plan
- All-zero state_in, both macro settings, NUM_QR=4 → state_out all zero, out_valid exactly 21 cycles after accept.
- Block test with SALSA20_FEEDFORWARD_EN, ROUNDS=20:
  - state_in words 0..15 = 61707865 3320646e 79622d32 6b206574 03020100 07060504 0b0a0908 0f0e0d0c 13121110 17161514 1b1a1918 1f1e1d1c 00000001 09000000 4a000000 00000000;
  - expect word0=e4e7f110, word15=4e3c50a2.
  - Without the macro, expect word0=837778ab.
- NUM_QR = 1, 2, 4 with identical random inputs → bit-identical state_out; latencies 81 / 41 / 21 cycles.
- Backpressure: hold out_ready=0 for 10 cycles → state_out stable, in_ready=0, new in_valid ignored. A single out_ready pulse → in_ready=1 next cycle.
- Reset mid-operation: assert reset_n=0 at compute cycle 7 → out_valid=0 and state_out=0 immediately. A following full block produces correct output.
- ROUNDS=2 with words 0,4,8,12 = 11111111, 01020304, 9b8d6f43, 01234567 and the rest zero, no feed-forward → output matches the software model, checked after the column sub-step (ea2a92f4, cb1cf8ce, 4581472e, 5881c4bb) via the internal state probe.
